// File: rtl/ram_cmd_ctrl.sv
// Byte-stream command parser that turns host write/read frames into word
// accesses on a single-port RAM with 1-cycle read latency.
module ram_cmd_ctrl #(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic                  ram_clke_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_mask_o,
  output logic [WORD_WIDTH-1:0] ram_wdata_o,
  input  logic [WORD_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o
);

  localparam int         BYTES     = WORD_WIDTH / 8;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hAC;

  typedef enum logic [3:0] {
    IDLE, ADDR0, ADDR1, LEN0, LEN1, WDATA, WRITE, RREQ, RWAIT, RSEND, ACK
  } state_t;

  state_t                  state, state_nxt;
  logic                    is_write;
  logic [7:0]              addr_lo;
  logic [ADDR_WIDTH-1:0]   addr, addr_inc;
  logic [15:0]             count;
  logic [WORD_WIDTH-1:0]   wdata, rshift;
  logic [1:0]              byte_idx;
  logic                    out_fire, in_fire, byte_last, word_last, len_zero;

  assign out_fire  = out_valid_i && out_ready_o;
  assign in_fire   = in_valid_o && in_ready_i;
  assign byte_last = (byte_idx == LAST_BYTE);
  assign word_last = (count == 16'd1);
  assign len_zero  = ({out_data_i, count[7:0]} == 16'd0);
  // Out-of-range addresses (non-power-of-2 depth) also fold back to 0.
  assign addr_inc  = (32'(addr) >= VECTOR_LENGTH - 1) ? '0 : addr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
    state_nxt = state;
    unique case (state)
      IDLE:  if (out_fire && (out_data_i == CMD_WRITE || out_data_i == CMD_READ)) state_nxt = ADDR0;
      ADDR0: if (out_fire) state_nxt = ADDR1;
      ADDR1: if (out_fire) state_nxt = LEN0;
      LEN0:  if (out_fire) state_nxt = LEN1;
      LEN1: if (out_fire) begin
        if (len_zero) state_nxt = is_write ? ACK : IDLE;
        else          state_nxt = is_write ? WDATA : RREQ;
      end
      WDATA: if (out_fire && byte_last) state_nxt = WRITE;
      WRITE: state_nxt = word_last ? ACK : WDATA;
      RREQ:  state_nxt = RWAIT;
      RWAIT: state_nxt = RSEND;
      RSEND: if (in_fire && byte_last) state_nxt = word_last ? IDLE : RREQ;
      ACK:   if (in_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_ready_o = 1'b0;
    in_valid_o  = 1'b0;
    in_data_o   = '0;
    ram_clke_o  = 1'b0;
    ram_we_o    = 1'b0;
    unique case (state)
      IDLE, ADDR0, ADDR1, LEN0, LEN1, WDATA: out_ready_o = !rst_i;
      WRITE: begin
        ram_clke_o = 1'b1;
        ram_we_o   = 1'b1;
      end
      RREQ:  ram_clke_o = 1'b1;
      RSEND: begin
        in_valid_o = 1'b1;
        in_data_o  = rshift[7:0];
      end
      ACK: begin
        in_valid_o = 1'b1;
        in_data_o  = ACK_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_write <= 1'b0;
      addr_lo  <= '0;
      addr     <= '0;
      count    <= '0;
      wdata    <= '0;
      rshift   <= '0;
      byte_idx <= '0;
    end else begin
      unique case (state)
        IDLE:  if (out_fire) is_write <= (out_data_i == CMD_WRITE);
        ADDR0: if (out_fire) addr_lo <= out_data_i;
        ADDR1: if (out_fire) addr <= ADDR_WIDTH'({out_data_i, addr_lo});
        LEN0:  if (out_fire) count[7:0] <= out_data_i;
        LEN1: if (out_fire) begin
          count[15:8] <= out_data_i;
          byte_idx    <= '0;
        end
        WDATA: if (out_fire) begin
          wdata[8*byte_idx +: 8] <= out_data_i;
          byte_idx               <= byte_last ? '0 : byte_idx + 1'b1;
        end
        WRITE: begin
          count <= count - 1'b1;
          addr  <= addr_inc;
        end
        RWAIT: begin
          rshift   <= ram_rdata_i;
          byte_idx <= '0;
        end
        RSEND: if (in_fire) begin
          rshift <= rshift >> 8;
          if (byte_last) begin
            byte_idx <= '0;
            count    <= count - 1'b1;
            addr     <= addr_inc;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr_o  = addr;
  assign ram_wdata_o = wdata;
  assign ram_mask_o  = '0;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Bench for ram_cmd_ctrl: directed and random frames checked against a
// word-level model of RAM contents, RAM access order and returned bytes.
module tb_ram_cmd_ctrl;

  localparam int VL = 512;
  localparam int WW = 16;
  localparam int AW = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [7:0]    out_data_i;
  logic          out_valid_i;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic          ram_clke_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [WW-1:0] ram_mask_o;
  logic [WW-1:0] ram_wdata_o;
  logic [WW-1:0] ram_rdata_i;
  logic          busy_o;

  ram_cmd_ctrl #(.VECTOR_LENGTH(VL), .WORD_WIDTH(WW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .ram_clke_o(ram_clke_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_mask_o(ram_mask_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } acc_t;

  logic [WW-1:0] ram_mem [VL];
  logic [WW-1:0] ref_mem [VL];
  acc_t          acc_q[$];
  logic [7:0]    rx_q[$];
  logic [15:0]   wq[$];
  int            checks, failures;
  int            cyc, dbl_strobe, unstable, mask_bad, lat_bad, lat_seen, rd_cyc, stall_cycles;
  int            hold_cnt = 0;
  int            hold_at = -1;
  bit            rand_ready = 1'b0;
  logic          prev_clke, prev_stall, prev_valid, rd_pending;
  logic [7:0]    prev_data;

  // RAM macro: 1-cycle read latency, mask bit 1 protects the bit.
  initial begin
    for (int i = 0; i < VL; i++) ram_mem[i] = 16'(i * 40503 + 7);
    ram_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      if (ram_clke_o) begin
        if (ram_we_o) ram_mem[ram_addr_o] = (ram_mem[ram_addr_o] & ram_mask_o) | (ram_wdata_o & ~ram_mask_o);
        else          ram_rdata_i <= ram_mem[ram_addr_o];
      end
    end
  end

  // IN-side consumer: optional random back-pressure plus a one-shot 5-cycle hold.
  initial begin
    in_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_at >= 0 && rx_q.size() == hold_at) begin
        hold_cnt = 5;
        hold_at  = -1;
      end
      if (hold_cnt > 0) begin
        in_ready_i = 1'b0;
        hold_cnt--;
      end else begin
        in_ready_i = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
    end
  end

  // Monitor sampled mid-cycle, away from the active edge.
  initial begin
    cyc = 0; dbl_strobe = 0; unstable = 0; mask_bad = 0; lat_bad = 0; lat_seen = 0;
    rd_cyc = 0; stall_cycles = 0;
    prev_clke = 0; prev_stall = 0; prev_valid = 0; rd_pending = 0; prev_data = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_i) begin
        prev_clke = 0; prev_stall = 0; prev_valid = 0; rd_pending = 0;
      end else begin
        if (ram_clke_o) begin
          acc_q.push_back(acc_t'{ram_we_o, ram_addr_o, ram_wdata_o});
          if (prev_clke) dbl_strobe++;
          if (!ram_we_o) begin
            rd_pending = 1;
            rd_cyc     = cyc;
          end
        end
        if (ram_mask_o != '0) mask_bad++;
        if (prev_stall && (!in_valid_o || in_data_o != prev_data)) unstable++;
        if (in_valid_o && !prev_valid && rd_pending) begin
          lat_seen++;
          if (cyc - rd_cyc != 2) lat_bad++;
          rd_pending = 0;
        end
        if (in_valid_o && !in_ready_i) stall_cycles++;
        if (in_valid_o && in_ready_i) rx_q.push_back(in_data_o);
        prev_clke  = ram_clke_o;
        prev_stall = in_valid_o && !in_ready_i;
        prev_data  = in_data_o;
        prev_valid = in_valid_o;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   n;
    logic timed_out;
    out_valid_i = 1'b0;
    repeat ($urandom_range(max_gap, 0)) tick();
    out_valid_i = 1'b1;
    out_data_i  = b;
    n           = 0;
    timed_out   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (out_ready_o) break;
      n++;
      if (n > 300) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) check("send_timeout", timed_out, 0);
    tick();
    out_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_ready"}, out_ready_o, 0);
    check({tag, "_in_valid"},  in_valid_o, 0);
    check({tag, "_in_data"},   in_data_o, 0);
    check({tag, "_clke"},      ram_clke_o, 0);
    check({tag, "_we"},        ram_we_o, 0);
    check({tag, "_addr"},      ram_addr_o, 0);
    check({tag, "_wdata"},     ram_wdata_o, 0);
    check({tag, "_mask"},      ram_mask_o, 0);
    check({tag, "_busy"},      busy_o, 0);
  endtask

  // Model: frame effect computed word by word, then compared against observed traffic.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len,
                           input int gap);
    acc_t        exp_acc[$];
    logic [7:0]  exp_rx[$];
    logic [15:0] w;
    int          a, c;
    a = int'(addr) % (1 << AW);
    for (int i = 0; i < int'(len); i++) begin
      if (cmd == 8'h01) begin
        ref_mem[a] = wq[i];
        exp_acc.push_back(acc_t'{1'b1, AW'(a), wq[i]});
      end else begin
        exp_acc.push_back(acc_t'{1'b0, AW'(a), 16'h0});
        exp_rx.push_back(ref_mem[a][7:0]);
        exp_rx.push_back(ref_mem[a][15:8]);
      end
      a = (a + 1) % VL;
    end
    if (cmd == 8'h01) exp_rx.push_back(8'hAC);
    acc_q.delete();
    rx_q.delete();
    send_byte(cmd, gap);
    send_byte(addr[7:0], gap);
    send_byte(addr[15:8], gap);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (cmd == 8'h01) begin
      for (int i = 0; i < int'(len); i++) begin
        w = wq[i];
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
      end
    end
    c = 0;
    while ((rx_q.size() < exp_rx.size() || busy_o) && c < 4000) begin
      tick();
      c++;
    end
    tick();
    tick();
    check("frame_busy_idle", busy_o, 0);
    check("frame_ready_idle", out_ready_o, 1);
    check("frame_acc_count", acc_q.size(), exp_acc.size());
    for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++) begin
      check("acc_we", acc_q[i].we, exp_acc[i].we);
      check("acc_addr", acc_q[i].addr, exp_acc[i].addr);
      if (exp_acc[i].we) check("acc_wdata", acc_q[i].data, exp_acc[i].data);
    end
    check("frame_rx_count", rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++) check("rx_byte", rx_q[i], exp_rx[i]);
  endtask

  int          len_r, mism;
  logic [15:0] addr_r;

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < VL; i++) ref_mem[i] = 16'(i * 40503 + 7);
    out_valid_i = 1'b0;
    out_data_i  = '0;
    rst_i       = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_i = 1'b0;
    tick();
    check("idle_out_ready", out_ready_o, 1);
    check("idle_busy", busy_o, 0);

    wq = '{16'h1234, 16'h5678};
    run_frame(8'h01, 16'h0010, 16'd2, 0);
    run_frame(8'h02, 16'h0010, 16'd2, 0);

    wq = '{16'($urandom), 16'($urandom)};
    run_frame(8'h01, 16'h01FF, 16'd2, 0);
    run_frame(8'h02, 16'h01FF, 16'd2, 0);

    wq = '{16'hBEEF};
    run_frame(8'h01, 16'hFE05, 16'd1, 1);
    run_frame(8'h02, 16'h0005, 16'd1, 0);

    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      len_r  = $urandom_range(5, 1);
      addr_r = 16'($urandom);
      wq.delete();
      for (int i = 0; i < len_r; i++) wq.push_back(16'($urandom));
      run_frame(8'h01, addr_r, 16'(len_r), 3);
      run_frame(8'h02, addr_r, 16'(len_r), 0);
    end
    rand_ready = 1'b0;

    stall_cycles = 0;
    hold_at      = 3;
    run_frame(8'h02, 16'h0010, 16'd4, 0);
    check("hold_stall_seen", stall_cycles >= 4, 1);

    acc_q.delete();
    rx_q.delete();
    send_byte(8'h55, 0);
    repeat (3) tick();
    check("junk_busy", busy_o, 0);
    check("junk_no_acc", acc_q.size(), 0);
    check("junk_no_rx", rx_q.size(), 0);
    wq.delete();
    run_frame(8'h01, 16'h0000, 16'd0, 0);
    run_frame(8'h02, 16'h0000, 16'd0, 0);

    acc_q.delete();
    rx_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h30, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    repeat (2) tick();
    rst_i = 1'b1;
    #2;
    check_reset_outputs("abort");
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("abort_no_acc", acc_q.size(), 0);
    check("abort_no_rx", rx_q.size(), 0);
    check("abort_busy", busy_o, 0);

    wq = '{16'hC0DE};
    run_frame(8'h01, 16'h0030, 16'd1, 2);
    run_frame(8'h02, 16'h0030, 16'd1, 0);

    mism = 0;
    for (int i = 0; i < VL; i++) if (ram_mem[i] !== ref_mem[i]) mism++;
    check("mem_contents_mismatches", mism, 0);
    check("read_latency_seen", lat_seen > 0, 1);
    check("read_latency_bad", lat_bad, 0);
    check("double_strobe", dbl_strobe, 0);
    check("in_stream_unstable", unstable, 0);
    check("mask_nonzero", mask_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
